// File: rtl/cache_pkg.sv
// Shared types and line-layout constants for the cache refill path.
package cache_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned LINE_W       = 137;
  localparam int unsigned BEATS        = 4;
  localparam int unsigned LINE_V_BIT   = 136;
  localparam int unsigned LINE_TAG_LSB = 128;
  localparam int unsigned LINE_TAG_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILL,
    WRITE
  } refill_state_t;

  // Bit position of word n inside the assembled line.
  function automatic int unsigned word_lsb(input int unsigned n);
    return n * WORD_W;
  endfunction

endpackage

// File: rtl/refill_line_buf.sv
// Four-word line buffer: slot-indexed word writes, clear on refill start,
// combinational assembly of {V, tag, w3, w2, w1, w0}.
module refill_line_buf
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = WORD_W,
  parameter int unsigned CACHE_DATA_WIDTH = LINE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        we,
  input  logic [1:0]                  slot,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [LINE_TAG_W-1:0]       tag,
  output logic [CACHE_DATA_WIDTH-1:0] line_data
);

  logic [DATA_WIDTH-1:0] words_q [BEATS];
  logic                  v_q;

  // A clear marks the start of a fresh line, so the valid bit is set there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      for (int unsigned i = 0; i < BEATS; i++) words_q[i] <= '0;
    end else if (clr) begin
      v_q <= 1'b1;
      for (int unsigned i = 0; i < BEATS; i++) words_q[i] <= '0;
    end else if (we) begin
      words_q[slot] <= wdata;
    end
  end

  always_comb begin
    line_data                                = '0;
    line_data[LINE_V_BIT]                    = v_q;
    line_data[LINE_TAG_LSB +: LINE_TAG_W]    = tag;
    for (int unsigned n = 0; n < BEATS; n++)
      line_data[word_lsb(n) +: DATA_WIDTH] = words_q[n];
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Read-miss refill controller: fetches a 4-word block, writes one full line.
// Build option CACHE_CRITICAL_WORD_FIRST_EN: start at the missed word, early restart.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned RAM_ADDRESS_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH          = WORD_W,
  parameter int unsigned CACHE_DATA_WIDTH    = LINE_W,
  parameter int unsigned CACHE_ADDRESS_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_req,
  input  logic [RAM_ADDRESS_WIDTH-1:0]   miss_addr,
  output logic                           mem_re,
  output logic [RAM_ADDRESS_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic                           line_we,
  output logic [CACHE_ADDRESS_WIDTH-1:0] line_index,
  output logic [CACHE_DATA_WIDTH-1:0]    line_data,
  output logic                           crit_valid,
  output logic [DATA_WIDTH-1:0]          crit_data,
  output logic                           stall
);

  refill_state_t                 state_q, state_d;
  logic [RAM_ADDRESS_WIDTH-1:0]  addr_q;
  logic [1:0]                    cnt_q, start, beat, beat_prev;
  logic                          accept, cap;
  logic                          unused_byte_off;

  assign unused_byte_off = ^addr_q[1:0];
  assign accept          = (state_q == IDLE) && miss_req;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign start = addr_q[3:2];
`else
  assign start = 2'b00;
`endif

  // cnt_q counts issued beats; beat is the block offset fetched this cycle.
  // In FILL cnt_q has wrapped to 0, so beat_prev names the last issued beat.
  assign beat      = start + cnt_q;
  assign beat_prev = beat - 2'd1;
  assign cap       = ((state_q == FETCH) && (cnt_q != 2'd0)) || (state_q == FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= miss_addr;
        cnt_q  <= '0;
      end else if (state_q == FETCH) begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    stall    = 1'b1;
    mem_re   = 1'b0;
    mem_addr = '0;
    line_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = miss_req;
        if (miss_req) state_d = FETCH;
      end
      FETCH: begin
        mem_re   = 1'b1;
        mem_addr = {addr_q[RAM_ADDRESS_WIDTH-1:4], beat, 2'b00};
        if (cnt_q == 2'(BEATS - 1)) state_d = FILL;
      end
      FILL: state_d = WRITE;
      WRITE: begin
        line_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign line_index = addr_q[4 +: CACHE_ADDRESS_WIDTH];

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  // First returned beat is the requested word; forward it straight from memory.
  assign crit_valid = (state_q == FETCH) && (cnt_q == 2'd1);
  assign crit_data  = crit_valid ? mem_rdata : '0;
`else
  assign crit_valid = (state_q == WRITE);
  assign crit_data  = crit_valid ? line_data[addr_q[3:2] * DATA_WIDTH +: DATA_WIDTH] : '0;
`endif

  refill_line_buf #(
    .DATA_WIDTH      (DATA_WIDTH),
    .CACHE_DATA_WIDTH(CACHE_DATA_WIDTH)
  ) u_line_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .we       (cap),
    .slot     (beat_prev),
    .wdata    (mem_rdata),
    .tag      (addr_q[RAM_ADDRESS_WIDTH-1 -: LINE_TAG_W]),
    .line_data(line_data)
  );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: cycle model plus directed literal checks.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         miss_req = 1'b0;
  logic [15:0]  miss_addr = 16'h0;
  logic         mem_re;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_rdata;
  logic         line_we;
  logic [3:0]   line_index;
  logic [136:0] line_data;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         stall;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF      = 1'b1;
  localparam int CRIT_CYC = 2;
`else
  localparam bit CWF      = 1'b0;
  localparam int CRIT_CYC = 6;
`endif

  always #5 clk = ~clk;

  cache_refill_ctrl #(
    .RAM_ADDRESS_WIDTH  (16),
    .DATA_WIDTH         (32),
    .CACHE_DATA_WIDTH   (137),
    .CACHE_ADDRESS_WIDTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .miss_req  (miss_req),
    .miss_addr (miss_addr),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .line_we   (line_we),
    .line_index(line_index),
    .line_data (line_data),
    .crit_valid(crit_valid),
    .crit_data (crit_data),
    .stall     (stall)
  );

  // Memory contents: block 0x123 reads as A0A0A0A0..A3A3A3A3, other blocks differ.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [7:0]  b;
    logic [11:0] d;
    b = 8'hA0 + {6'd0, a[3:2]};
    d = a[15:4] ^ 12'h123;
    return {b, b, b, b} ^ {4'h0, d, 16'h0};
  endfunction

  always @(posedge clk) mem_rdata <= mem_re ? mem_word(mem_addr) : 32'h5A5A_5A5A;

  task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: t = cycles since miss acceptance (0 = idle), ma = accepted address.
  int unsigned t = 0;
  logic [15:0] ma = 16'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else if (t == 0) begin
      if (miss_req) begin
        t  <= 1;
        ma <= miss_addr;
      end
    end else t <= (t == 6) ? 0 : t + 1;
  end

  logic [1:0]   m_off;
  logic         m_re, m_we, m_cv, m_stall;
  logic [136:0] m_line;
  logic [31:0]  m_crit;

  always @(negedge clk) begin
    m_stall = (t != 0) || miss_req;
    m_re    = (t >= 1) && (t <= 4);
    m_we    = (t == 6);
    m_cv    = CWF ? (t == 2) : (t == 6);
    m_off   = CWF ? 2'(ma[3:2] + (t - 1)) : 2'(t - 1);
    m_line  = {1'b1, ma[15:8],
               mem_word({ma[15:4], 4'hC}), mem_word({ma[15:4], 4'h8}),
               mem_word({ma[15:4], 4'h4}), mem_word({ma[15:4], 4'h0})};
    m_crit  = mem_word({ma[15:4], ma[3:2], 2'b00});
    check("m_stall", 137'(stall), 137'(m_stall));
    check("m_mem_re", 137'(mem_re), 137'(m_re));
    check("m_line_we", 137'(line_we), 137'(m_we));
    check("m_crit_valid", 137'(crit_valid), 137'(m_cv));
    if (m_re) check("m_mem_addr", 137'(mem_addr), 137'({ma[15:4], m_off, 2'b00}));
    if (m_we) begin
      check("m_line_index", 137'(line_index), 137'(ma[7:4]));
      check("m_line_data", line_data, m_line);
    end
    if (m_cv) check("m_crit_data", 137'(crit_data), 137'(m_crit));
    if (!rst_n) begin
      check("m_rst_addr", 137'(mem_addr), 137'(0));
      check("m_rst_line", line_data, 137'(0));
      check("m_rst_index", 137'(line_index), 137'(0));
      check("m_rst_crit", 137'(crit_data), 137'(0));
    end
  end

  task automatic run_miss(input string nm, input logic [15:0] a, input logic [3:0][15:0] ea,
                          input logic [3:0] eidx, input logic [136:0] eline, input logic [31:0] ecrit);
    @(posedge clk); #1 miss_req = 1'b1; miss_addr = a;
    @(negedge clk);
    check({nm, "_stall_c0"}, 137'(stall), 137'(1));
    @(posedge clk); #1 miss_req = 1'b0; miss_addr = 16'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) check({nm, "_mem_addr"}, 137'(mem_addr), 137'(ea[k-1]));
      if (k == CRIT_CYC) begin
        check({nm, "_crit_valid"}, 137'(crit_valid), 137'(1));
        check({nm, "_crit_data"}, 137'(crit_data), 137'(ecrit));
      end
      if (k == 6) begin
        check({nm, "_line_we"}, 137'(line_we), 137'(1));
        check({nm, "_line_index"}, 137'(line_index), 137'(eidx));
        check({nm, "_line_data"}, line_data, eline);
      end
    end
    @(negedge clk);
    check({nm, "_stall_c7"}, 137'(stall), 137'(0));
  endtask

  localparam logic [136:0] LINE_123 = {1'b1, 8'h12, 32'hA3A3A3A3, 32'hA2A2A2A2,
                                       32'hA1A1A1A1, 32'hA0A0A0A0};
  localparam logic [136:0] LINE_FFF = {1'b1, 8'hFF, 32'hAD7FA3A3, 32'hAC7EA2A2,
                                       32'hAF7DA1A1, 32'hAE7CA0A0};
  localparam logic [136:0] LINE_004 = {1'b1, 8'h00, 32'hA284A3A3, 32'hA385A2A2,
                                       32'hA086A1A1, 32'hA187A0A0};

  logic [13:0] pulses;
  int unsigned we_cnt;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall", 137'(stall), 137'(0));
    check("rst_mem_re", 137'(mem_re), 137'(0));
    check("rst_line_we", 137'(line_we), 137'(0));
    check("rst_crit_valid", 137'(crit_valid), 137'(0));
    check("rst_line_data", line_data, 137'(0));
    rst_n = 1'b1;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    run_miss("m1234", 16'h1234, {16'h1230, 16'h123C, 16'h1238, 16'h1234}, 4'h3, LINE_123, 32'hA1A1A1A1);
    run_miss("m123C", 16'h123C, {16'h1238, 16'h1234, 16'h1230, 16'h123C}, 4'h3, LINE_123, 32'hA3A3A3A3);
`else
    run_miss("m1234", 16'h1234, {16'h123C, 16'h1238, 16'h1234, 16'h1230}, 4'h3, LINE_123, 32'hA1A1A1A1);
    run_miss("m123C", 16'h123C, {16'h123C, 16'h1238, 16'h1234, 16'h1230}, 4'h3, LINE_123, 32'hA3A3A3A3);
`endif
    run_miss("mFFF3", 16'hFFF3, {16'hFFFC, 16'hFFF8, 16'hFFF4, 16'hFFF0}, 4'hF, LINE_FFF, 32'hAE7CA0A0);

    // miss_req held for 10 cycles: line_we expected in cycles 6 and 13 only.
    @(posedge clk); #1 miss_req = 1'b1; miss_addr = 16'h2220;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      pulses[k] = line_we;
      @(posedge clk); #1;
      if (k == 9) miss_req = 1'b0;
    end
    check("held_we_pattern", 137'(pulses), 137'(14'h2040));
    repeat (2) @(posedge clk);

    // Reset during cycle 3 of a refill: partial line dropped.
    #1 miss_req = 1'b1; miss_addr = 16'h5678;
    @(posedge clk); #1 miss_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stall", 137'(stall), 137'(0));
    check("midrst_mem_re", 137'(mem_re), 137'(0));
    check("midrst_line_we", 137'(line_we), 137'(0));
    @(negedge clk);
    rst_n = 1'b1;
    we_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (line_we) we_cnt++;
    end
    check("midrst_no_we", 137'(we_cnt), 137'(0));
    run_miss("m0040", 16'h0040, {16'h004C, 16'h0048, 16'h0044, 16'h0040}, 4'h4, LINE_004, 32'hA187A0A0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-handling stage that sits directly downstream of the spatial RAM-cache's miss detection. On a read miss it fetches the four 32-bit words of the missing 16-byte block from word-wide main memory, assembles a 137-bit cache line `{V, tag, w3, w2, w1, w0}`, and writes it into the cache array in a single cycle. It holds the pipeline stalled for the whole refill, so the cache array only ever receives complete, valid lines.

## Interface
Parameters:
- `RAM_ADDRESS_WIDTH`, 16: byte address width. Tag = A[15:8], index = A[7:4], block offset = A[3:2], byte offset = A[1:0].
- `DATA_WIDTH`, 32: word width.
- `CACHE_DATA_WIDTH`, 137: line width. Bit 136 = V, [135:128] = tag, [127:0] = w3..w0.
- `CACHE_ADDRESS_WIDTH`, 4: index width (16 sets).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `miss_req` in 1: cache reports a read miss this cycle.
- `miss_addr` in 16: byte address of the missing access.
- `mem_re` out 1: main-memory read strobe.
- `mem_addr` out 16: word-aligned memory address, [1:0] = 00.
- `mem_rdata` in 32: memory data, valid the cycle after `mem_re`.
- `line_we` out 1: cache line write strobe, one-cycle pulse.
- `line_index` out 4: set to write.
- `line_data` out 137: `{1'b1, tag, w3, w2, w1, w0}`.
- `crit_valid` out 1: requested word available on `crit_data`.
- `crit_data` out 32: requested word.
- `stall` out 1: pipeline hold.

## Operation
- States: IDLE, FETCH, FILL, WRITE.
- IDLE:
  - `stall = miss_req`.
  - On a clock edge with `miss_req=1`: latch `miss_addr`, clear the beat counter, go to FETCH.
- FETCH (4 cycles):
  - `mem_re=1`.
  - `mem_addr = {tag, index, beat[1:0], 2'b00}`.
  - Beat counter increments each cycle, 2 bits, wraps mod 4.
  - Data returned for the previous beat is captured into word slot `beat_prev`.
  - After the 4th issue, go to FILL.
- FILL: `mem_re=0`; capture the last beat; go to WRITE.
- WRITE:
  - `line_we=1` for exactly one cycle, with `line_index = latched[7:4]`.
  - Next state is IDLE.
- `stall=1` in FETCH, FILL and WRITE.
- `line_data` is driven from the line buffer in every state; it is only meaningful while `line_we=1`.
- Word slot mapping: slot n holds the memory word at block offset n, regardless of fetch order.
- `miss_req` is ignored outside IDLE; it is not queued.
- The upstream is stalled, so no writes arrive during a refill.
- Reset, async and valid in any state, including mid-refill:
  - state = IDLE; all outputs 0.
  - Line buffer and beat counter are cleared.
  - The partial line is discarded and no `line_we` is issued.

## Timing
- Cycle 0: IDLE, `miss_req` sampled.
- Cycles 1–4: FETCH.
- Cycle 5: FILL.
- Cycle 6: WRITE, `line_we` pulse.
- Cycle 7: IDLE, `stall=0` unless a new `miss_req` arrives.
- Refill latency: 6 cycles from miss acceptance to `line_we`. The stall lasts 7 cycles including cycle 0.
- The earliest next miss is accepted at the edge ending cycle 7.
- Memory read latency is fixed at 1 cycle. There is no backpressure from memory.

## Configuration
- `CACHE_CRITICAL_WORD_FIRST_EN` defined:
  - Beat order starts at `miss_addr[3:2]` and wraps, e.g. offset 3 gives 3, 0, 1, 2.
  - `crit_valid` pulses in cycle 2 with `crit_data` = the requested word (early restart data).
- Undefined:
  - Beat order is 0, 1, 2, 3.
  - `crit_valid` pulses in cycle 6 (the WRITE cycle) with the requested word.
- Line contents and `line_we` timing are identical in both builds.

## Structure
- `cache_pkg` holds:
  - the state enum (`refill_state_t`);
  - line field offsets (V=136, tag 135:128, word n at [32n+31:32n]);
  - width constants;
  - a `BEATS=4` constant.
- One sub-module, `refill_line_buf`: a 4×32 word buffer with slot-indexed write, clear, and a combinational concat to `line_data`.
- The FSM, beat counter and address generation live in the top module.

## Test plan
- Reset → all outputs 0 and state IDLE. Raising `miss_req` in the first cycle after `rst_n` rises gives `stall=1` that cycle.
- Default build, miss at 0x1234, memory words 0x1230 = 0xA0A0A0A0 … 0x123C = 0xA3A3A3A3:
  - `mem_addr` = 0x1230, 0x1234, 0x1238, 0x123C in cycles 1–4.
  - `line_we` in cycle 6, `line_index` = 3.
  - `line_data = {1, 0x12, A3.., A2.., A1.., A0..}`.
  - `crit_valid` in cycle 6 with 0xA1A1A1A1.
- `CACHE_CRITICAL_WORD_FIRST_EN` build, miss at 0x123C:
  - `mem_addr` = 0x123C, 0x1230, 0x1234, 0x1238.
  - `crit_valid` in cycle 2 with 0xA3A3A3A3.
  - `line_data` identical to the previous scenario.
- `miss_req` held high for 10 cycles → exactly one `line_we`, in cycle 6. The second refill starts at the cycle-7 edge and its `line_we` lands in cycle 13.
- Reset asserted during cycle 3 → no `line_we`; `stall=0` immediately. A following miss at 0x0040 completes normally with `line_index` = 4.
- Miss at 0xFFF3 → `mem_addr` = 0xFFF0 … 0xFFFC with no address overflow; `line_index` = 0xF, tag = 0xFF.
